btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Upstream conditioning stage for the positive-edge detector.
- Takes a raw, asynchronous, bouncing mechanical input such as a push-button or switch.
- Synchronises it into the clk domain with a 2-flop synchroniser.
- Runs a stability counter and FSM that emit a clean level, db_out, which drives the edge detector's sig input directly.

Parameters:
- STABLE_CYCLES, default 500000, number of consecutive cycles the synchronised input must differ from db_out before db_out follows it (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, default $clog2(STABLE_CYCLES), counter width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw, asynchronous, possibly bouncing input.
- db_out  output  1  debounced level, registered, glitch-free.
- busy  output  1  high while a transition is pending (FSM in PEND_HIGH or PEND_LOW), registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - both synchroniser flops = 0, counter = 0, state = STABLE_LOW;
  - db_out = 0, busy = 0;
  - all hold until the first rising clk edge after rst_n deasserts.
- Synchroniser: s1 <= btn_in, s2 <= s1. The FSM uses only s2; btn_in never feeds logic directly.
- States (2-bit encoding): STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
- STABLE_LOW:
  - s2 = 0: stay, cnt = 0;
  - s2 = 1: go PEND_HIGH, cnt <= 1.
- PEND_HIGH:
  - s2 = 0: go STABLE_LOW, cnt <= 0 (bounce rejected, db_out stays 0);
  - s2 = 1 and cnt == STABLE_CYCLES-1: go STABLE_HIGH, db_out <= 1, cnt <= 0;
  - else cnt <= cnt+1.
- STABLE_HIGH and PEND_LOW: mirror images of the above, with polarities swapped.
- Outputs:
  - db_out and busy are registered and change only on the state-transition edge;
  - busy = 1 exactly in the PEND states.
- Latency:
  - btn_in changes before edge 0 and stays stable → s2 changes after edge 1, db_out changes after edge STABLE_CYCLES+1;
  - total STABLE_CYCLES+2 edges including the capture edge.
- Any return of s2 to the db_out level during PEND restarts the count from 0. Pulses shorter than STABLE_CYCLES cycles (after synchronisation) never reach db_out.
- Counter arithmetic:
  - unsigned, CNT_W bits;
  - never exceeds STABLE_CYCLES-1, so no wrap-around is possible;
  - no saturation logic is needed beyond the compare.
- db_out changes at most once per STABLE_CYCLES+1 cycles, so each downstream edge-detector pulse is one clean rise.
- Simultaneous events: reset dominates everything. A terminal count and an s2 reversal on the same edge cannot coincide, because terminal commit requires s2 ≠ db_out on that edge.
- Reset mid-PEND: pending count is discarded, db_out forced to 0. If btn_in is held high through reset, db_out rises STABLE_CYCLES+2 edges after deassertion.
- Illegal state encoding (none reachable): the default branch returns to STABLE_LOW with db_out = 0 and cnt = 0.

Decomposition:
- Shared package btn_pkg holds:
  - typedef enum logic [1:0] db_state_t {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW};
  - constant DEFAULT_STABLE_CYCLES = 500000.
- One natural sub-module: sync_2ff (1-bit, async active-low reset, reset value 0). It is reusable for any other asynchronous input in the design.

Test Plan (STABLE_CYCLES = 4 throughout):
- Reset: assert rst_n = 0 mid-cycle with btn_in = 1 → db_out = 0 and busy = 0 immediately, with no clk edge needed. Release → db_out = 1 after the 6th edge.
- Clean press: btn_in 0→1 before edge 0, held → busy = 1 after edge 2, db_out = 1 after edge 5, busy = 0 after edge 5.
- Bounce rejection: btn_in high for 2 cycles, low for 1, high for 3, then low → db_out stays 0 throughout, busy toggles, count restarts each time.
- Bounce then settle: btn_in toggles every cycle for 6 cycles, then holds 1 → db_out = 1 exactly 6 edges after the final 0→1 transition.
- Release: from STABLE_HIGH, btn_in 1→0 held → db_out = 0 after edge 5. A 3-cycle low glitch produces no change on db_out.
- Reset mid-PEND_HIGH (cnt = 2): pulse rst_n low → db_out = 0, cnt = 0, state STABLE_LOW. With btn_in still 1, db_out rises after a full 6-edge latency.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM state type and default stability window
package btn_pkg;
   typedef enum logic [1:0] {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW} db_state_t;
   localparam int DEFAULT_STABLE_CYCLES = 500000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input, resets to 0
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_q, q_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {q_q, meta_q} <= 2'b00;
      else        {q_q, meta_q} <= {meta_q, d};
   end
   assign q = q_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncing input and only follows it after STABLE_CYCLES steady cycles
module btn_debounce
   import btn_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic db_out,
   output logic busy
);
   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   logic s2;
   db_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic db_q, db_d, busy_q, busy_d;
   sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(btn_in), .q(s2));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      case (state_q)
         STABLE_LOW: begin
            state_d = s2 ? PEND_HIGH : STABLE_LOW;
            cnt_d   = s2 ? CNT_W'(1) : '0;
         end
         PEND_HIGH:
            if (!s2) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = STABLE_HIGH;
               db_d    = 1'b1;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         STABLE_HIGH: begin
            state_d = s2 ? STABLE_HIGH : PEND_LOW;
            cnt_d   = s2 ? '0 : CNT_W'(1);
         end
         PEND_LOW:
            if (s2) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = STABLE_LOW;
               db_d    = 1'b0;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         default: begin
            state_d = STABLE_LOW;
            db_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == PEND_HIGH) || (state_d == PEND_LOW);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         busy_q  <= busy_d;
      end
   end
   assign db_out = db_q;
   assign busy   = busy_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized and directed scoreboard bench against a run-length reference model
module tb_btn_debounce;
   localparam int S = 4;
   logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b0;
   logic db_out, busy;
   int checks = 0, errors = 0;
   logic [1:0] exp_q[$];
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
   int run = 0;
   btn_debounce #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .db_out(db_out), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: {db_out,busy} got %b expected %b", nm, $time, act, exp);
      end
   endtask
   // Reference: db flips once s2 has disagreed with it on S consecutive edges
   task automatic step(input logic b);
      @(negedge clk);
      btn_in = b;
      if (m_s2 != m_db) begin
         run++;
         if (run == S) begin
            m_db = ~m_db;
            run = 0;
         end
      end else run = 0;
      m_s2 = m_s1;
      m_s1 = b;
      exp_q.push_back({m_db, run != 0});
   endtask
   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask
   task automatic do_reset(input string nm);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk(nm, {db_out, busy}, 2'b00);
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; run = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask
   initial begin : monitor
      logic [1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", {db_out, busy}, e);
         end
      end
   end
   initial begin : stim
      #1 chk("reset_initial", {db_out, busy}, 2'b00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      hold(0, 3);
      hold(1, 8);
      hold(0, 8);
      hold(1, 8);
      hold(0, 3);
      hold(1, 8);
      hold(0, 8);
      hold(1, 2); hold(0, 1); hold(1, 3); hold(0, 8);
      for (int i = 0; i < 6; i++) step(i[0] ? 1'b0 : 1'b1);
      hold(1, 10);
      do_reset("reset_from_high");
      hold(1, 10);
      hold(0, 8);
      hold(1, 4);
      do_reset("reset_mid_pend");
      hold(1, 10);
      for (int i = 0; i < 400; i++) hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * S + 2));
      hold(0, 10);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
